dma_ch_scheduler: RTL and testbench

Per-channel request scheduler for the DMA engine's shared AHB master port. It takes the eight peripheral dma_req lines and arbitrates them round-robin among enabled channels. It owns the bus request/grant handshake and counts burst beats. It drives ch_select to steer the per-channel response fan-out, and issues per-channel dma_ack and dma_tc pulses plus a terminal-count interrupt.

---
 rtl/dma_ch_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dma_ch_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ch_scheduler.sv
// Round-robin DMA channel scheduler for a shared AHB master port.
// It owns the bus request/grant handshake, counts burst beats and issues per-channel ack/tc/err pulses.
module dma_ch_scheduler #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int BEAT_W = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              HCLK,
  input  logic              HRST,
  input  logic [NUM_CH-1:0] dma_req,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [BEAT_W-1:0] cfg_beats,
  input  logic              hgrant,
  input  logic              hready,
  input  logic              hresp_err,
  output logic              hreq,
  output logic [CH_W-1:0]   ch_select,
  output logic              beat_valid,
  output logic              last_beat,
  output logic              busy,
  output logic [NUM_CH-1:0] dma_ack,
  output logic [NUM_CH-1:0] dma_tc,
  output logic [NUM_CH-1:0] dma_err,
  output logic              irq_tc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DONE, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    rem_q [NUM_CH];
  logic [CNT_W-1:0]    rem_d [NUM_CH];
  logic [BEAT_W-1:0]   beats_q [NUM_CH];
  logic [BEAT_W-1:0]   beats_d [NUM_CH];

  logic [NUM_CH-1:0]   elig;
  logic                found;
  logic [CH_W-1:0]     pick;
  logic                cfg_ok;
  logic [CH_W-1:0]     rr_next;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = dma_req[i] & ch_en[i] & (rem_q[i] != '0);
    end
  end

  // First eligible channel scanning upward from rr_ptr with wrap-around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = rr_q;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_q) + k) % NUM_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  assign rr_next   = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
  assign busy      = (state_q != S_IDLE);
  assign ch_select = ch_q;
  // The owning channel's configuration is frozen until its burst retires.
  assign cfg_ok    = cfg_wr && (int'(cfg_ch) < NUM_CH) && !(busy && (cfg_ch == ch_q));

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    hreq       = 1'b0;
    beat_valid = 1'b0;
    last_beat  = 1'b0;
    dma_ack    = '0;
    dma_tc     = '0;
    dma_err    = '0;
    irq_tc     = 1'b0;

    if (cfg_ok) begin
      rem_d[cfg_ch]   = cfg_len;
      beats_d[cfg_ch] = cfg_beats;
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          ch_d       = pick;
          beat_cnt_d = beats_q[pick];
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        hreq = 1'b1;
        if (hgrant) state_d = S_XFER;
      end
      S_XFER: begin
        hreq       = 1'b1;
        beat_valid = hgrant;
        last_beat  = (beat_cnt_q == '0);
        if (!hgrant) begin
          state_d = S_REQ;
        end else if (hready) begin
          if (hresp_err)                state_d = S_ERR;
          else if (beat_cnt_q == '0)    state_d = S_DONE;
          else                          beat_cnt_d = beat_cnt_q - BEAT_W'(1);
        end
      end
      S_DONE: begin
        dma_ack[ch_q] = 1'b1;
        if (rem_q[ch_q] != '0) rem_d[ch_q] = rem_q[ch_q] - CNT_W'(1);
        if (rem_q[ch_q] == CNT_W'(1)) begin
          dma_tc[ch_q] = 1'b1;
          irq_tc       = 1'b1;
        end
        rr_d    = rr_next;
        state_d = S_IDLE;
      end
      S_ERR: begin
        dma_err[ch_q] = 1'b1;
        irq_tc        = 1'b1;
        rem_d[ch_q]   = '0;
        rr_d          = rr_next;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      rr_q       <= '0;
      beat_cnt_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rem_q[i]   <= '0;
        beats_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
    end
  end

endmodule

// File: tb/tb_dma_ch_scheduler.sv
// Directed bench for dma_ch_scheduler: one task per scenario with inline checks.
module tb_dma_ch_scheduler;

  logic        HCLK, HRST;
  logic [7:0]  dma_req, ch_en;
  logic        cfg_wr;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_len;
  logic [3:0]  cfg_beats;
  logic        hgrant, hready, hresp_err;
  logic        hreq, beat_valid, last_beat, busy, irq_tc;
  logic [2:0]  ch_select;
  logic [7:0]  dma_ack, dma_tc, dma_err;

  int total = 0;
  int bad   = 0;

  dma_ch_scheduler dut (
    .HCLK(HCLK), .HRST(HRST), .dma_req(dma_req), .ch_en(ch_en),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_len(cfg_len), .cfg_beats(cfg_beats),
    .hgrant(hgrant), .hready(hready), .hresp_err(hresp_err),
    .hreq(hreq), .ch_select(ch_select), .beat_valid(beat_valid), .last_beat(last_beat),
    .busy(busy), .dma_ack(dma_ack), .dma_tc(dma_tc), .dma_err(dma_err), .irq_tc(irq_tc)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRST = 1'b1; dma_req = '0; ch_en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_len = '0;
    cfg_beats = '0; hgrant = 1'b0; hready = 1'b0; hresp_err = 1'b0;
    cyc(); cyc();
    HRST = 1'b0;
  endtask

  task automatic cfg(input int ch, input int len, input int beats);
    cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_len = 16'(len); cfg_beats = 4'(beats);
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    HRST = 1'b1; dma_req = 8'hFF; ch_en = 8'hFF; cfg_wr = 1'b0; cfg_ch = '0; cfg_len = '0;
    cfg_beats = '0; hgrant = 1'b1; hready = 1'b1; hresp_err = 1'b0;
    cyc(); cyc();
    outs = {hreq, ch_select, beat_valid, last_beat, busy, dma_ack, dma_tc, dma_err, irq_tc};
    total++; if (outs !== '0) begin bad++; $display("FAIL rst_outputs: got %h want 0", outs); end
    HRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (hreq !== 1'b0) begin bad++; $display("FAIL rst_hreq_after_release%0d: got %b want 0", i, hreq); end
    end
    // Abort mid-transfer with reset.
    dma_req = 8'h01; ch_en = 8'h01;
    cfg(0, 1, 3);
    cyc(); cyc();
    total++; if (beat_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_abort_xfer: got %b want 1", beat_valid); end
    HRST = 1'b1;
    cyc();
    outs = {hreq, ch_select, beat_valid, last_beat, busy, dma_ack, dma_tc, dma_err, irq_tc};
    total++; if (outs !== '0) begin bad++; $display("FAIL rst_abort_outputs: got %h want 0", outs); end
    HRST = 1'b0;
    cyc(); cyc(); cyc();
    total++; if (hreq !== 1'b0) begin bad++; $display("FAIL rst_abort_no_restart: got %b want 0", hreq); end
  endtask

  task automatic test_single();
    int first_hreq = -1, ack_n = 0, tc_n = 0, irq_n = 0, bv_n = 0, lb_n = 0, bpos = 0;
    int bad_lb = 0, bad_sel = 0, tc_at = -1;
    int ack_at [2] = '{-1, -1};
    do_reset();
    ch_en = 8'h08; dma_req = 8'h08; hgrant = 1'b1; hready = 1'b1;
    cfg(3, 2, 3);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (hreq && first_hreq < 0) first_hreq = i;
      if (hreq && ch_select != 3'd3) bad_sel++;
      if (beat_valid) begin
        bv_n++; bpos++;
        if (last_beat) begin lb_n++; if (bpos != 4) bad_lb++; end
      end
      if (dma_ack != '0) begin
        total++; if (dma_ack !== 8'h08) begin bad++; $display("FAIL single_ack_value: got %h want 08", dma_ack); end
        if (ack_n < 2) ack_at[ack_n] = i;
        ack_n++; bpos = 0;
      end
      if (dma_tc != '0) begin
        total++; if (dma_tc !== 8'h08) begin bad++; $display("FAIL single_tc_value: got %h want 08", dma_tc); end
        tc_n++; tc_at = i;
      end
      if (irq_tc) irq_n++;
    end
    dma_req = '0;
    total++; if (first_hreq != 0) begin bad++; $display("FAIL single_req_latency: got %0d want 0", first_hreq); end
    total++; if (bad_sel != 0) begin bad++; $display("FAIL single_ch_select: got %0d wrong cycles want 0", bad_sel); end
    total++; if (bv_n != 8) begin bad++; $display("FAIL single_beats: got %0d want 8", bv_n); end
    total++; if (lb_n != 2 || bad_lb != 0) begin bad++; $display("FAIL single_last_beat: got %0d/%0d want 2/0", lb_n, bad_lb); end
    total++; if (ack_n != 2) begin bad++; $display("FAIL single_ack_count: got %0d want 2", ack_n); end
    total++; if (ack_at[0] != 5 || ack_at[1] != 12) begin bad++; $display("FAIL single_ack_timing: got %0d,%0d want 5,12", ack_at[0], ack_at[1]); end
    total++; if (tc_n != 1 || tc_at != 12) begin bad++; $display("FAIL single_tc: got n=%0d at=%0d want n=1 at=12", tc_n, tc_at); end
    total++; if (irq_n != 1) begin bad++; $display("FAIL single_irq: got %0d want 1", irq_n); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ack [3];
    int n;
    exp_ack[0] = 8'h01; exp_ack[1] = 8'h02; exp_ack[2] = 8'h20;
    do_reset();
    ch_en = 8'h23; hgrant = 1'b1; hready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      dma_req = '0;
      cfg(0, 1, 0); cfg(1, 1, 0); cfg(5, 1, 0);
      dma_req = 8'h23;
      n = 0;
      for (int i = 0; i < 30; i++) begin
        cyc();
        if (dma_ack != '0) begin
          if (n < 3) begin
            total++; if (dma_ack !== exp_ack[n]) begin bad++; $display("FAIL rr_order_r%0d_%0d: got %h want %h", r, n, dma_ack, exp_ack[n]); end
            total++; if (dma_tc !== dma_ack) begin bad++; $display("FAIL rr_tc_r%0d_%0d: got %h want %h", r, n, dma_tc, dma_ack); end
          end
          n++;
        end
      end
      total++; if (n != 3) begin bad++; $display("FAIL rr_count_r%0d: got %0d want 3", r, n); end
    end
    dma_req = '0;
  endtask

  task automatic test_grant_loss();
    int beats = 0, acks = 0, lastpos = -1, lb_n = 0;
    logic [7:0] ack_val = '0;
    bit dropped = 0;
    do_reset();
    ch_en = 8'h04; dma_req = 8'h04; hgrant = 1'b1; hready = 1'b1;
    cfg(2, 1, 7);
    for (int i = 0; i < 60 && acks == 0; i++) begin
      if (beats == 3 && !dropped) begin
        dropped = 1; hgrant = 1'b0;
        for (int j = 0; j < 4; j++) begin
          #1;
          total++; if (beat_valid !== 1'b0) begin bad++; $display("FAIL gl_beat_valid_%0d: got %b want 0", j, beat_valid); end
          total++; if (hreq !== 1'b1) begin bad++; $display("FAIL gl_hreq_%0d: got %b want 1", j, hreq); end
          cyc();
        end
        hgrant = 1'b1; #1;
        total++; if (beat_valid !== 1'b0 || hreq !== 1'b1) begin bad++; $display("FAIL gl_back_in_req: got bv=%b hreq=%b want bv=0 hreq=1", beat_valid, hreq); end
      end
      if (beat_valid) begin
        beats++;
        if (last_beat) begin lb_n++; lastpos = beats; end
      end
      if (dma_ack != '0) begin acks++; ack_val = dma_ack; end
      cyc();
    end
    dma_req = '0;
    total++; if (beats != 8) begin bad++; $display("FAIL gl_total_beats: got %0d want 8", beats); end
    total++; if (lb_n != 1 || lastpos != 8) begin bad++; $display("FAIL gl_last_beat: got n=%0d pos=%0d want n=1 pos=8", lb_n, lastpos); end
    total++; if (acks != 1 || ack_val !== 8'h04) begin bad++; $display("FAIL gl_ack: got n=%0d val=%h want n=1 val=04", acks, ack_val); end
  endtask

  task automatic test_error();
    int hreq_n = 0, ack_n = 0, tc_n = 0;
    do_reset();
    ch_en = 8'h40; dma_req = 8'h40; hgrant = 1'b1; hready = 1'b1;
    cfg(6, 3, 3);
    cyc();
    total++; if (hreq !== 1'b1 || ch_select !== 3'd6) begin bad++; $display("FAIL err_req: got hreq=%b sel=%0d want hreq=1 sel=6", hreq, ch_select); end
    cyc();
    total++; if (beat_valid !== 1'b1) begin bad++; $display("FAIL err_beat1: got %b want 1", beat_valid); end
    cyc();
    total++; if (beat_valid !== 1'b1 || last_beat !== 1'b0) begin bad++; $display("FAIL err_beat2: got bv=%b lb=%b want bv=1 lb=0", beat_valid, last_beat); end
    hresp_err = 1'b1;
    cyc();
    hresp_err = 1'b0;
    total++; if (dma_err !== 8'h40) begin bad++; $display("FAIL err_pulse: got %h want 40", dma_err); end
    total++; if (irq_tc !== 1'b1) begin bad++; $display("FAIL err_irq: got %b want 1", irq_tc); end
    total++; if (dma_ack !== 8'h00 || dma_tc !== 8'h00 || hreq !== 1'b0) begin bad++; $display("FAIL err_no_ack: got ack=%h tc=%h hreq=%b want 00/00/0", dma_ack, dma_tc, hreq); end
    cyc();
    total++; if (dma_err !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got err=%h busy=%b want 00/0", dma_err, busy); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (hreq) hreq_n++;
      if (dma_ack != '0) ack_n++;
    end
    total++; if (hreq_n != 0 || ack_n != 0) begin bad++; $display("FAIL err_ineligible: got hreq=%0d ack=%0d want 0/0", hreq_n, ack_n); end
    cfg(6, 1, 0);
    ack_n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dma_ack == 8'h40) ack_n++;
      if (dma_tc == 8'h40) tc_n++;
    end
    dma_req = '0;
    total++; if (ack_n != 1 || tc_n != 1) begin bad++; $display("FAIL err_rearm: got ack=%0d tc=%0d want 1/1", ack_n, tc_n); end
  endtask

  task automatic test_cfg_collision();
    logic [7:0] acks [3];
    logic [7:0] tcs [3];
    int blen [3];
    int n = 0, bc = 0;
    logic [7:0] exp_ack [3];
    logic [7:0] exp_tc [3];
    int exp_len [3];
    exp_ack[0] = 8'h10; exp_ack[1] = 8'h02; exp_ack[2] = 8'h10;
    exp_tc[0]  = 8'h00; exp_tc[1]  = 8'h02; exp_tc[2]  = 8'h10;
    exp_len[0] = 8;     exp_len[1] = 1;     exp_len[2] = 8;
    for (int k = 0; k < 3; k++) begin acks[k] = '0; tcs[k] = '0; blen[k] = 0; end
    do_reset();
    ch_en = 8'h12; dma_req = 8'h12; hgrant = 1'b1; hready = 1'b1;
    cfg(4, 2, 7);
    for (int i = 0; i < 80 && n < 3; i++) begin
      cfg_wr = 1'b0;
      if (i == 2) begin cfg_wr = 1'b1; cfg_ch = 3'd4; cfg_len = 16'd1; cfg_beats = 4'd0; end
      if (i == 3) begin cfg_wr = 1'b1; cfg_ch = 3'd1; cfg_len = 16'd1; cfg_beats = 4'd0; end
      if (i == 2) begin
        total++; if (busy !== 1'b1 || ch_select !== 3'd4 || beat_valid !== 1'b1) begin bad++; $display("FAIL col_in_xfer: got busy=%b sel=%0d bv=%b want 1/4/1", busy, ch_select, beat_valid); end
      end
      if (beat_valid) bc++;
      if (dma_ack != '0) begin
        acks[n] = dma_ack; tcs[n] = dma_tc; blen[n] = bc; bc = 0; n++;
      end
      cyc();
    end
    cfg_wr = 1'b0; dma_req = '0;
    total++; if (n != 3) begin bad++; $display("FAIL col_burst_count: got %0d want 3", n); end
    for (int k = 0; k < 3; k++) begin
      total++; if (acks[k] !== exp_ack[k] || tcs[k] !== exp_tc[k] || blen[k] != exp_len[k]) begin
        bad++; $display("FAIL col_burst%0d: got ack=%h tc=%h beats=%0d want ack=%h tc=%h beats=%0d", k, acks[k], tcs[k], blen[k], exp_ack[k], exp_tc[k], exp_len[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_grant_loss();
    test_error();
    test_cfg_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
